// File: rtl/gf_pkg.sv
// Shared constants, opcodes and FSM state encoding for the GF(2^m) op sequencer.
package gf_pkg;

    localparam int unsigned GF_DW    = 4;
    localparam int unsigned GF_OPC_W = 2;

    localparam logic [GF_OPC_W-1:0] OP_ADD = 2'd0;
    localparam logic [GF_OPC_W-1:0] OP_MUL = 2'd1;
    localparam logic [GF_OPC_W-1:0] OP_RED = 2'd2;
    localparam logic [GF_OPC_W-1:0] OP_EXP = 2'd3;

    // Multiplicative identity of the field, seed of the exponent accumulator.
    localparam logic [GF_DW-1:0] ONE = GF_DW'(1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADD,
        S_MUL,
        S_RED,
        S_EXP_INIT,
        S_EXP_SQ,
        S_EXP_SQ_RED,
        S_EXP_ML,
        S_EXP_ML_RED,
        S_DONE
    } state_e;

endpackage

// File: rtl/gf_op_sequencer_if.sv
// Command and result handshake bundle between a requester and the sequencer.
interface gf_op_sequencer_if
    import gf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = GF_DW,
    parameter int unsigned OPC_W      = GF_OPC_W
);

    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [OPC_W-1:0]        cmd_op;
    logic [DATA_WIDTH-1:0]   cmd_a;
    logic [DATA_WIDTH-1:0]   cmd_b;
    logic [DATA_WIDTH:0]     cmd_poly;
    logic [2*DATA_WIDTH-1:0] cmd_red_in;
    logic                    res_valid;
    logic                    res_ready;
    logic [DATA_WIDTH-1:0]   res_data;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_poly, cmd_red_in, res_ready,
        input  cmd_ready, res_valid, res_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_poly, cmd_red_in, res_ready,
        output cmd_ready, res_valid, res_data
    );

endinterface

// File: rtl/gf_seq_dp_mux.sv
// Datapath control/operand selection for a given sequencer state; all zero when idle.
module gf_seq_dp_mux
    import gf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = GF_DW
) (
    input  state_e                  state_i,
    input  logic [DATA_WIDTH-1:0]   a_i,
    input  logic [DATA_WIDTH-1:0]   b_i,
    input  logic [DATA_WIDTH-1:0]   acc_i,
    input  logic [2*DATA_WIDTH-1:0] prod_i,
    input  logic [DATA_WIDTH:0]     poly_i,
    output logic                    sum_o,
    output logic                    red_o,
    output logic [DATA_WIDTH-1:0]   x_o,
    output logic [DATA_WIDTH-1:0]   y_o,
    output logic [DATA_WIDTH:0]     poly_o,
    output logic [2*DATA_WIDTH-1:0] reduc_o
);

    always_comb begin
        sum_o   = 1'b0;
        red_o   = 1'b0;
        x_o     = '0;
        y_o     = '0;
        poly_o  = '0;
        reduc_o = '0;
        unique case (state_i)
            S_ADD: begin
                sum_o = 1'b1;
                x_o   = a_i;
                y_o   = b_i;
            end
            S_MUL: begin
                x_o = a_i;
                y_o = b_i;
            end
            S_EXP_SQ: begin
                x_o = acc_i;
                y_o = acc_i;
            end
            S_EXP_ML: begin
                x_o = acc_i;
                y_o = a_i;
            end
            S_RED, S_EXP_SQ_RED, S_EXP_ML_RED: begin
                red_o   = 1'b1;
                poly_o  = poly_i;
                reduc_o = prod_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/gf_op_sequencer.sv
// Sequences a combinational GF(2^m) datapath through add, multiply+reduce, reduce and
// MSB-first square-and-multiply exponentiation, one command at a time.
module gf_op_sequencer
    import gf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = GF_DW,
    parameter int unsigned OPC_W      = GF_OPC_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    gf_op_sequencer_if.slave        bus,
    output logic                    dp_sum_funct,
    output logic                    dp_exp_funct,
    output logic                    dp_red_funct,
    output logic                    dp_carry_option,
    output logic [DATA_WIDTH-1:0]   dp_a,
    output logic [DATA_WIDTH-1:0]   dp_b,
    output logic [DATA_WIDTH:0]     dp_polyn_red_in,
    output logic [2*DATA_WIDTH-1:0] dp_reduc_in,
    input  logic [DATA_WIDTH-1:0]   dp_out,
    input  logic [2*DATA_WIDTH-1:0] dp_mult_out
);

    localparam int unsigned IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   a_q, a_d, b_q, b_d, acc_q, acc_d, res_data_q, res_data_d;
    logic [DATA_WIDTH:0]     poly_q, poly_d;
    logic [2*DATA_WIDTH-1:0] prod_q, prod_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    cmd_ready_q, cmd_ready_d, res_valid_q, res_valid_d;

    logic                    sum_c, red_c;
    logic [DATA_WIDTH-1:0]   x_c, y_c;
    logic [DATA_WIDTH:0]     poly_c;
    logic [2*DATA_WIDTH-1:0] reduc_c;
    logic                    dp_sum_q, dp_red_q;
    logic [DATA_WIDTH-1:0]   dp_a_q, dp_b_q;
    logic [DATA_WIDTH:0]     dp_poly_q;
    logic [2*DATA_WIDTH-1:0] dp_reduc_q;

    // Next-state, operand capture and result latching.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        poly_d     = poly_q;
        prod_d     = prod_q;
        acc_d      = acc_q;
        idx_d      = idx_q;
        res_data_d = res_data_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    a_d    = bus.cmd_a;
                    b_d    = bus.cmd_b;
                    poly_d = bus.cmd_poly;
                    // Standalone RED reduces the latched red_in through the product register.
                    prod_d = bus.cmd_red_in;
                    case (bus.cmd_op)
                        OPC_W'(OP_ADD): state_d = S_ADD;
                        OPC_W'(OP_MUL): state_d = S_MUL;
                        OPC_W'(OP_RED): state_d = S_RED;
                        OPC_W'(OP_EXP): state_d = S_EXP_INIT;
                        default:        state_d = S_IDLE;
                    endcase
                end
            end
            S_ADD, S_RED: begin
                acc_d   = dp_out;
                state_d = S_DONE;
            end
            S_MUL: begin
                prod_d  = dp_mult_out;
                state_d = S_RED;
            end
            S_EXP_INIT: begin
                acc_d   = DATA_WIDTH'(ONE);
                idx_d   = IW'(DATA_WIDTH - 1);
                state_d = S_EXP_SQ;
            end
            S_EXP_SQ, S_EXP_ML: begin
                prod_d  = dp_mult_out;
                state_d = (state_q == S_EXP_SQ) ? S_EXP_SQ_RED : S_EXP_ML_RED;
            end
            S_EXP_SQ_RED, S_EXP_ML_RED: begin
                acc_d = dp_out;
                if (state_q == S_EXP_SQ_RED && b_q[idx_q]) begin
                    state_d = S_EXP_ML;
                end else if (idx_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q - IW'(1);
                    state_d = S_EXP_SQ;
                end
            end
            S_DONE: begin
                if (res_valid_q && bus.res_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_DONE && state_q != S_DONE) res_data_d = acc_d;
        cmd_ready_d = (state_d == S_IDLE);
        res_valid_d = (state_d == S_DONE);
    end

    // Datapath drive is selected from the upcoming state so the dp_* ports come straight from flops.
    gf_seq_dp_mux #(.DATA_WIDTH(DATA_WIDTH)) u_dp_mux (
        .state_i (state_d),
        .a_i     (a_d),
        .b_i     (b_d),
        .acc_i   (acc_d),
        .prod_i  (prod_d),
        .poly_i  (poly_d),
        .sum_o   (sum_c),
        .red_o   (red_c),
        .x_o     (x_c),
        .y_o     (y_c),
        .poly_o  (poly_c),
        .reduc_o (reduc_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            poly_q      <= '0;
            prod_q      <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            res_data_q  <= '0;
            cmd_ready_q <= 1'b0;
            res_valid_q <= 1'b0;
            dp_sum_q    <= 1'b0;
            dp_red_q    <= 1'b0;
            dp_a_q      <= '0;
            dp_b_q      <= '0;
            dp_poly_q   <= '0;
            dp_reduc_q  <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            poly_q      <= poly_d;
            prod_q      <= prod_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            res_data_q  <= res_data_d;
            cmd_ready_q <= cmd_ready_d;
            res_valid_q <= res_valid_d;
            dp_sum_q    <= sum_c;
            dp_red_q    <= red_c;
            dp_a_q      <= x_c;
            dp_b_q      <= y_c;
            dp_poly_q   <= poly_c;
            dp_reduc_q  <= reduc_c;
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_data    = res_data_q;
    assign dp_sum_funct    = dp_sum_q;
    assign dp_red_funct    = dp_red_q;
    assign dp_exp_funct    = 1'b0;
    assign dp_carry_option = 1'b0;
    assign dp_a            = dp_a_q;
    assign dp_b            = dp_b_q;
    assign dp_polyn_red_in = dp_poly_q;
    assign dp_reduc_in     = dp_reduc_q;

endmodule

// File: tb/tb_gf_op_sequencer.sv
// Scoreboard bench for gf_op_sequencer with a behavioural stand-in for the GF datapath.
module tb_gf_op_sequencer;
    import gf_pkg::*;

    localparam int unsigned DW  = 4;
    localparam int          PER = 10;

    logic clk = 1'b0;
    logic rst_n;
    always #(PER/2) clk = ~clk;

    gf_op_sequencer_if #(.DATA_WIDTH(DW), .OPC_W(2)) bus_if ();

    logic            dp_sum_funct, dp_exp_funct, dp_red_funct, dp_carry_option;
    logic [DW-1:0]   dp_a, dp_b, dp_out;
    logic [DW:0]     dp_polyn_red_in;
    logic [2*DW-1:0] dp_reduc_in, dp_mult_out;

    gf_op_sequencer #(.DATA_WIDTH(DW), .OPC_W(2)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus_if),
        .dp_sum_funct    (dp_sum_funct),
        .dp_exp_funct    (dp_exp_funct),
        .dp_red_funct    (dp_red_funct),
        .dp_carry_option (dp_carry_option),
        .dp_a            (dp_a),
        .dp_b            (dp_b),
        .dp_polyn_red_in (dp_polyn_red_in),
        .dp_reduc_in     (dp_reduc_in),
        .dp_out          (dp_out),
        .dp_mult_out     (dp_mult_out)
    );

    // Stand-in combinational datapath: carry-less product and polynomial long division.
    function automatic logic [2*DW-1:0] clmul(input logic [DW-1:0] x, input logic [DW-1:0] y);
        logic [2*DW-1:0] r = '0;
        for (int i = 0; i < DW; i++) if (y[i]) r ^= ({{DW{1'b0}}, x} << i);
        return r;
    endfunction

    function automatic logic [DW-1:0] polymod(input logic [2*DW-1:0] v, input logic [DW:0] p);
        logic [2*DW-1:0] r = v;
        for (int i = 2*DW-1; i >= int'(DW); i--) if (r[i]) r ^= ({{(DW-1){1'b0}}, p} << (i - DW));
        return r[DW-1:0];
    endfunction

    always_comb begin
        dp_mult_out = clmul(dp_a, dp_b);
        dp_out      = dp_sum_funct ? (dp_a ^ dp_b) : polymod(dp_reduc_in, dp_polyn_red_in);
    end

    // Reference field arithmetic: shift-and-add multiply, powers by repeated multiplication.
    function automatic logic [DW-1:0] ref_mul(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW:0] p);
        logic [DW:0]   x = {1'b0, a};
        logic [DW-1:0] r = '0;
        for (int i = 0; i < DW; i++) begin
            if (b[i]) r ^= x[DW-1:0];
            x = x << 1;
            if (x[DW]) x ^= p;
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] ref_red(input logic [2*DW-1:0] v, input logic [DW:0] p);
        logic [DW-1:0] r  = '0;
        logic [DW-1:0] xi = DW'(1);
        for (int i = 0; i < 2*DW; i++) begin
            if (v[i]) r ^= xi;
            xi = ref_mul(xi, DW'(2), p);
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] ref_pow(input logic [DW-1:0] a, input logic [DW-1:0] e, input logic [DW:0] p);
        logic [DW-1:0] r = DW'(1);
        for (int i = 0; i < int'(e); i++) r = ref_mul(r, a, p);
        return r;
    endfunction

    function automatic logic [DW-1:0] model(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [DW:0] p, input logic [2*DW-1:0] rin);
        case (op)
            2'd0:    return a ^ b;
            2'd1:    return ref_mul(a, b, p);
            2'd2:    return ref_red(rin, p);
            default: return ref_pow(a, b, p);
        endcase
    endfunction

    typedef struct {
        logic [DW-1:0] data;
        bit            dc;
        longint        t;
        int            lat;
        int            reds;
        int            sums;
    } sb_t;

    sb_t sb[$];
    int  checks = 0;
    int  errors = 0;
    bit  force_low = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic scramble();
        bus_if.cmd_op     = 2'($urandom);
        bus_if.cmd_a      = DW'($urandom);
        bus_if.cmd_b      = DW'($urandom);
        bus_if.cmd_poly   = (DW+1)'($urandom);
        bus_if.cmd_red_in = (2*DW)'($urandom);
    endtask

    task automatic send(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW:0] p, input logic [2*DW-1:0] rin,
                        input logic [DW-1:0] expv, input bit dc);
        int  n = 0;
        int  pc;
        sb_t e;
        @(negedge clk);
        while (!bus_if.cmd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!bus_if.cmd_ready) begin
            chk("cmd_accept_timeout", 0, 1);
            return;
        end
        bus_if.cmd_valid  = 1'b1;
        bus_if.cmd_op     = op;
        bus_if.cmd_a      = a;
        bus_if.cmd_b      = b;
        bus_if.cmd_poly   = p;
        bus_if.cmd_red_in = rin;
        pc     = $countones(b);
        e.data = expv;
        e.dc   = dc;
        e.t    = $time;
        e.lat  = (op == 2'd0) ? 2 : (op == 2'd1) ? 3 : (op == 2'd2) ? 2 : 2 + 2*DW + 2*pc;
        e.reds = (op == 2'd0) ? 0 : (op == 2'd3) ? DW + pc : 1;
        e.sums = (op == 2'd0) ? 1 : 0;
        sb.push_back(e);
        @(negedge clk);
        bus_if.cmd_valid = 1'b0;
        scramble();
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", sb.size(), 0);
    endtask

    // Consumer backpressure, changed just after the active edge.
    always @(posedge clk) begin
        #2;
        bus_if.res_ready = force_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // Monitor: pops the scoreboard on each new result and checks hold behaviour while waiting.
    bit            prev_valid = 1'b0;
    int            sum_cnt = 0;
    int            red_cnt = 0;
    logic [DW-1:0] held;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            sum_cnt    = 0;
            red_cnt    = 0;
        end else begin
            if (dp_sum_funct) sum_cnt++;
            if (dp_red_funct) red_cnt++;
            if (bus_if.res_valid) begin
                chk("cmd_ready_low_in_done", bus_if.cmd_ready, 0);
                if (!prev_valid) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_result", 1, 0);
                    end else begin
                        sb_t e;
                        e = sb.pop_front();
                        if (!e.dc) chk("res_data", bus_if.res_data, e.data);
                        chk("latency", ($time - e.t) / PER, e.lat);
                        chk("dp_sum_cycles", sum_cnt, e.sums);
                        chk("dp_red_cycles", red_cnt, e.reds);
                    end
                    sum_cnt = 0;
                    red_cnt = 0;
                end else begin
                    chk("res_data_stable", bus_if.res_data, held);
                end
                held = bus_if.res_data;
            end
            prev_valid = bus_if.res_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired with %0d results pending", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n            = 1'b0;
        bus_if.cmd_valid = 1'b0;
        bus_if.res_ready = 1'b0;
        scramble();
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", bus_if.cmd_ready, 0);
        chk("rst_res_valid", bus_if.res_valid, 0);
        chk("rst_res_data", bus_if.res_data, 0);
        chk("rst_dp_sum", dp_sum_funct, 0);
        chk("rst_dp_red", dp_red_funct, 0);
        chk("rst_dp_a", dp_a, 0);
        chk("rst_dp_reduc", dp_reduc_in, 0);
        chk("rst_dp_carry", dp_carry_option, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_cmd_ready", bus_if.cmd_ready, 1);

        // Directed cases with hand-computed results for p = x^4+x+1.
        send(2'd0, 4'd12, 4'd10, 5'd19, 8'd0,  4'd6, 1'b0);
        send(2'd1, 4'd12, 4'd10, 5'd19, 8'd0,  4'd1, 1'b0);
        send(2'd2, 4'd0,  4'd0,  5'd19, 8'd90, 4'd5, 1'b0);
        send(2'd3, 4'd2,  4'd4,  5'd19, 8'd0,  4'd3, 1'b0);
        send(2'd3, 4'd2,  4'd15, 5'd19, 8'd0,  4'd1, 1'b0);
        send(2'd3, 4'd7,  4'd0,  5'd19, 8'd0,  4'd1, 1'b0);
        send(2'd3, 4'd0,  4'd0,  5'd19, 8'd0,  4'd1, 1'b0);
        send(2'd3, 4'd0,  4'd5,  5'd19, 8'd0,  4'd0, 1'b0);
        // Degenerate polynomial: value is don't-care but the FSM must finish on time.
        send(2'd3, 4'd3,  4'd11, 5'd3,  8'd0,  4'd0, 1'b1);
        send(2'd0, 4'd5,  4'd9,  5'd19, 8'd0,  4'd12, 1'b0);

        for (int k = 0; k < 40; k++) begin
            logic [1:0]      op;
            logic [DW-1:0]   a, b;
            logic [DW:0]     p;
            logic [2*DW-1:0] rin;
            op  = 2'($urandom);
            a   = DW'($urandom);
            b   = DW'($urandom);
            p   = {1'b1, DW'($urandom)};
            rin = (2*DW)'($urandom);
            send(op, a, b, p, rin, model(op, a, b, p, rin), 1'b0);
        end
        wait_drain();

        // Held result under backpressure, with a competing command that must be ignored.
        force_low = 1'b1;
        send(2'd1, 4'd12, 4'd10, 5'd19, 8'd0, 4'd1, 1'b0);
        begin
            int n = 0;
            while (!bus_if.res_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        for (int k = 0; k < 5; k++) begin
            bus_if.cmd_valid = 1'b1;
            bus_if.cmd_op    = 2'd0;
            bus_if.cmd_a     = 4'd1;
            bus_if.cmd_b     = 4'd2;
            chk("bp_res_valid", bus_if.res_valid, 1);
            chk("bp_cmd_ready", bus_if.cmd_ready, 0);
            chk("bp_res_data", bus_if.res_data, 1);
            @(negedge clk);
        end
        bus_if.cmd_valid = 1'b0;
        force_low = 1'b0;
        wait_drain();

        // Reset during the first square of a^15: the pending result is dropped.
        send(2'd3, 4'd2, 4'd15, 5'd19, 8'd0, 4'd1, 1'b0);
        @(negedge clk);
        chk("exp_sq_dp_a", dp_a, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_res_valid", bus_if.res_valid, 0);
        chk("midrst_cmd_ready", bus_if.cmd_ready, 0);
        chk("midrst_dp_a", dp_a, 0);
        void'(sb.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        send(2'd0, 4'd12, 4'd10, 5'd19, 8'd0, 4'd6, 1'b0);
        wait_drain();
        chk("dp_exp_funct_idle", dp_exp_funct, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gf_op_sequencer.md
Name: gf_op_sequencer

Overview:
- Multi-cycle controller for the combinational GF(2^m) datapath `top`: carry-less add, carry-less multiply, reduction by a programmable polynomial.
- Accepts one command at a time over a valid/ready handshake and sequences the datapath.
- Runs a single op (ADD, MUL+reduce, or standalone REDUCE) or a full modular exponentiation a^e mod p by MSB-first square-and-multiply.
- Registers each datapath result and returns the reduced field element over a valid/ready result port.

Parameters:
- DATA_WIDTH, 4, field degree m; operand/result width.
- OPC_W, 2, opcode width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  OPC_W  0=ADD, 1=MUL, 2=RED, 3=EXP.
- cmd_a  in  DATA_WIDTH  operand a / exponent base.
- cmd_b  in  DATA_WIDTH  operand b / exponent e.
- cmd_poly  in  DATA_WIDTH+1  reduction polynomial p; bit DATA_WIDTH must be 1.
- cmd_red_in  in  2*DATA_WIDTH  value reduced by RED.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  DATA_WIDTH  result.
- dp_sum_funct, dp_exp_funct, dp_red_funct, dp_carry_option  out  1 each  datapath controls.
- dp_a, dp_b  out  DATA_WIDTH  datapath operands.
- dp_polyn_red_in  out  DATA_WIDTH+1  datapath polynomial.
- dp_reduc_in  out  2*DATA_WIDTH  datapath reduction input.
- dp_out  in  DATA_WIDTH  datapath narrow result.
- dp_mult_out  in  2*DATA_WIDTH  datapath carry-less product.

Behaviour:
- Reset (async, rst_n=0), all flops cleared:
  - state=IDLE; cmd_ready=0 during reset, 1 in IDLE after reset.
  - res_valid=0, res_data=0.
  - All dp_* outputs 0, except dp_carry_option=0 permanently (GF/carry-less mode).
- Accept: cmd_valid&&cmd_ready in IDLE latches op, a, b, poly, red_in. cmd_ready=1 only in IDLE.
- Datapath is combinational. Each non-IDLE/DONE state drives dp_* for exactly one cycle; the result is captured at the end of that cycle.
- Per-state datapath drive:
  - ADD: sum=1, dp_a=a, dp_b=b; capture dp_out.
  - MUL: sum=0, exp=0, red=0, dp_a=x, dp_b=y; capture dp_mult_out into prod.
  - RED: red=1, dp_reduc_in=prod (or latched red_in for op RED), dp_polyn_red_in=poly; capture dp_out.
- States: IDLE, ADD, MUL, RED, EXP_INIT, EXP_SQ, EXP_SQ_RED, EXP_ML, EXP_ML_RED, DONE.
- Op paths:
  - ADD: IDLE→ADD→DONE.
  - MUL: IDLE→MUL(x=a,y=b)→RED→DONE.
  - RED: IDLE→RED→DONE.
  - EXP: IDLE→EXP_INIT (acc=1, bit index i=DATA_WIDTH-1).
- EXP loop, per bit: EXP_SQ(x=y=acc)→EXP_SQ_RED (acc←dp_out).
  - If e[i]=1: EXP_ML(x=acc, y=a)→EXP_ML_RED (acc←dp_out).
  - If i==0 go DONE, else i←i-1 and loop to EXP_SQ.
- Latency, accept edge to res_valid high: ADD 2, MUL 3, RED 2, EXP 2+2*DATA_WIDTH+2*popcount(e) cycles.
- DONE: res_valid=1, res_data stable until res_valid&&res_ready, then return to IDLE. A same-cycle new command is not accepted (cmd_ready=0 in DONE).
- res_ready low holds DONE indefinitely. dp_* return to 0 outside active states.
- Edge values:
  - e=0: result 1.
  - a=0, e≠0: result 0.
  - a=0, e=0: result 1.
- A poly with MSB=0 is still processed; the result is unspecified but the FSM must terminate and stay live.
- rst_n asserted mid-operation: immediate return to IDLE, result discarded, res_valid=0.
- Command inputs are ignored outside IDLE; later changes must not affect the in-flight op.

Decomposition:
- Shared package gf_pkg: opcode localparams OP_ADD/OP_MUL/OP_RED/OP_EXP, state enum, DATA_WIDTH-dependent constant ONE.
- The datapath `top` is instantiated at integration level, not inside this block.
- One natural sub-module, gf_seq_dp_mux: combinational dp_* driver selected by state. FSM, counter and accumulator stay in gf_op_sequencer.

Test Plan:
- ADD a=12, b=10 → res_data=6, res_valid 2 cycles after accept, dp_sum_funct high exactly one cycle.
- MUL a=12, b=10, poly=19 → dp_mult_out=120 captured, res_data=1, latency 3.
- RED red_in=90, poly=19 → res_data=5, latency 2.
- EXP a=2, e=4, poly=19 → 3 (latency 12); a=2, e=15, poly=19 → 1 (latency 18); a=7, e=0 → 1.
- Backpressure: hold res_ready=0 for 5 cycles after MUL → res_data stable, cmd_ready=0, a second cmd_valid ignored until handshake completes.
- Assert rst_n=0 during EXP_SQ of a=2, e=15 → res_valid=0 immediately, then fresh ADD 12,10 returns 6.
